// File: rtl/mmc_s_if.sv
// Operand load / result bus for the LCM engine.
interface mmc_s_if;
    logic        ld;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [63:0] res;
    logic        done;
    logic        busy;
    logic [31:0] iter;

    modport master (output ld, i_a, i_b, input res, done, busy, iter);
    modport slave  (input ld, i_a, i_b, output res, done, busy, iter);
endinterface

// File: rtl/mmc_s.sv
// Least common multiple by racing running multiples of each operand until they meet.
// Latency: one edge per addition plus one terminating edge; ld is ignored while busy.
module mmc_s (
    input  logic   clk,
    input  logic   rst,
    mmc_s_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_r, b_r;
    logic [63:0] ma, mb;
    logic [63:0] res_r;
    logic [31:0] iter_r;
    logic        accept;
    logic        zero_op;
    logic        match;

    always_comb begin
        accept    = bus.ld && (state != RUN);
        zero_op   = (bus.i_a == 32'd0) || (bus.i_b == 32'd0);
        match     = (ma == mb);
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept) state_nxt = zero_op ? DONE : RUN;
            RUN:        if (match)  state_nxt = DONE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            ma     <= '0;
            mb     <= '0;
            res_r  <= '0;
            iter_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r    <= bus.i_a;
                b_r    <= bus.i_b;
                ma     <= {32'd0, bus.i_a};
                mb     <= {32'd0, bus.i_b};
                iter_r <= '0;
                res_r  <= '0;
            end else if (state == RUN) begin
                // The terminating edge counts as an iteration too.
                if (iter_r != 32'hFFFF_FFFF)
                    iter_r <= iter_r + 32'd1;
                if (match)
                    res_r <= ma;
                else if (ma < mb)
                    ma <= ma + {32'd0, a_r};
                else
                    mb <= mb + {32'd0, b_r};
            end
        end
    end

    assign bus.res  = res_r;
    assign bus.iter = iter_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_mmc_s.sv
// Bench for mmc_s: directed scenarios plus randomized operands against an arithmetic LCM model.
module tb_mmc_s;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mmc_s_if bus();

    mmc_s dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_lcm(input longint unsigned a, input longint unsigned b);
        longint unsigned x = a, y = b, t;
        if (a == 0 || b == 0) return 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return (a / x) * b;
    endfunction

    // Additions needed: each multiple climbs from the operand to the lcm; plus the final equal edge.
    function automatic longint unsigned ref_iter(input longint unsigned a, input longint unsigned b);
        longint unsigned l = ref_lcm(a, b);
        if (l == 0) return 0;
        return (l / a - 1) + (l / b - 1) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [31:0] a, input logic [31:0] b);
        bus.ld  = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        tick();
        bus.ld  = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        longint unsigned exp_it;
        exp_it = ref_iter(a, b);
        do_ld(a, b);
        chk({tag, "_busy"}, bus.busy, (a != 0 && b != 0));
        wait_done(2000, cyc);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_res"}, bus.res, ref_lcm(a, b));
        chk({tag, "_iter"}, bus.iter, exp_it);
        chk({tag, "_lat"}, cyc, exp_it);
    endtask

    initial begin
        int cyc;
        logic [31:0] g, a, b;
        logic [63:0] hold_res;
        logic [31:0] hold_iter;

        rst = 1'b1;
        bus.ld = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_res", bus.res, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_iter", bus.iter, 0);

        run_case("lcm_4_6", 32'd4, 32'd6);
        chk("lcm_4_6_abs", bus.res, 64'd12);
        run_case("eq_7_7", 32'd7, 32'd7);
        chk("eq_7_7_iter_abs", bus.iter, 1);
        run_case("zero_0_9", 32'd0, 32'd9);
        chk("zero_lat_abs", bus.iter, 0);
        run_case("zero_5_0", 32'd5, 32'd0);

        // Second ld mid-computation must be ignored.
        do_ld(32'd21, 32'd6);
        tick();
        bus.ld = 1'b1; bus.i_a = 32'd3; bus.i_b = 32'd5;
        tick();
        bus.ld = 1'b0;
        chk("midld_busy", bus.busy, 1);
        wait_done(2000, cyc);
        chk("midld_done", bus.done, 1);
        chk("midld_res", bus.res, 64'd42);
        chk("midld_iter", bus.iter, ref_iter(21, 6));

        // Reset in the middle of a long computation.
        do_ld(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        repeat (10) tick();
        chk("long_iter10", bus.iter, 10);
        chk("long_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_res", bus.res, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_iter", bus.iter, 0);
        repeat (3) tick();
        chk("mrst_idle_done", bus.done, 0);
        run_case("lcm_12_18", 32'd12, 32'd18);
        chk("lcm_12_18_abs", bus.res, 64'd36);

        // Randomized 16-bit operands sharing a factor so the iteration count stays small.
        for (int i = 0; i < 25; i++) begin
            g = $urandom_range(1, 8191);
            a = g * $urandom_range(1, 8);
            b = g * $urandom_range(1, 8);
            run_case($sformatf("rnd%0d", i), a, b);
            hold_res  = ref_lcm(a, b);
            hold_iter = 32'(ref_iter(a, b));
            for (int k = 0; k < 3; k++) begin
                bus.i_a = $urandom;
                bus.i_b = $urandom;
                tick();
            end
            chk($sformatf("rnd%0d_hold_res", i), bus.res, hold_res);
            chk($sformatf("rnd%0d_hold_done", i), bus.done, 1);
            chk($sformatf("rnd%0d_hold_iter", i), bus.iter, hold_iter);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmc_s.md
MMC_S -- requirements
Module: mmc_s

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: ld  input  1  start pulse; samples i_a/i_b when accepted.
REQ-005 SHALL have port: i_a  input  32  first operand, unsigned.
REQ-006 SHALL have port: i_b  input  32  second operand, unsigned.
REQ-007 SHALL have port: res  output  64  least common multiple of the last accepted operands.
REQ-008 SHALL have port: done  output  1  high while res is valid.
REQ-009 SHALL have port: busy  output  1  high while a computation is in progress.
REQ-010 SHALL have port: iter  output  32  count of RUN cycles spent on the last or current computation.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-012 SHALL hold registers a_r, b_r (32 bit, captured operands) and ma, mb (64 bit, running multiples).
REQ-013 SHALL accept ld only in IDLE or DONE: on that edge a_r<=i_a, b_r<=i_b, ma<=i_a, mb<=i_b, iter<=0, res<=0.
REQ-014 SHALL, on ld accept with i_a==0 or i_b==0, go directly to DONE with res=0 and iter=0 (lcm(0,x)=0).
REQ-015 SHALL otherwise go to RUN on the accepting edge.
REQ-016 SHALL, on each RUN edge: if ma==mb, go to DONE and set res<=ma; else if ma<mb, ma<=ma+a_r; else mb<=mb+b_r.
REQ-017 SHALL increment iter on every RUN edge, including the terminating edge; iter saturates at 0xFFFFFFFF.
REQ-018 SHALL zero-extend a_r and b_r to 64 bits before addition; ma and mb never exceed lcm <= a*b < 2^64, so no overflow handling is required.
REQ-019 SHALL ignore ld while in RUN: operands are not resampled and the computation continues undisturbed.
REQ-020 SHALL hold res, done and iter stable in DONE until the next accepted ld.
REQ-021 SHALL give, for nonzero operands, a latency of exactly N+1 edges from the accepting edge to done high, where N is the number of additions performed.
REQ-022 SHALL treat i_a==i_b (nonzero) as finishing on the first RUN edge: res=i_a, iter=1.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set state=IDLE, res=0, done=0, busy=0, iter=0, and a_r=b_r=ma=mb=0.
REQ-024 SHALL give rst priority over ld and over any RUN update, including a reset asserted mid-computation.
REQ-025 SHALL require an accepted ld after reset before done asserts again.

Verification
REQ-026 SHALL cover this scenario: rst then ld with a=4, b=6 -> busy for 4 edges (ma 8, mb 12, ma 12, equal), then done=1, res=12, iter=4.
REQ-027 SHALL cover this scenario: ld with a=7, b=7 -> done after 1 RUN edge, res=7, iter=1.
REQ-028 SHALL cover this scenario: ld with a=0, b=9 -> done=1 on the next cycle, res=0, busy never high, iter=0.
REQ-029 SHALL cover this scenario: ld with a=21, b=6, then ld pulsed again with a=3, b=5 mid-RUN -> second ld ignored, final res=42.
REQ-030 SHALL cover this scenario: ld with a=0xFFFFFFFF, b=0xFFFFFFFE, rst asserted for 1 cycle after 10 RUN edges -> IDLE, all outputs 0; a following ld with a=12, b=18 -> res=36.
REQ-031 SHALL cover this scenario: randomized nonzero 16-bit operands checked against a*b/gcd(a,b), with res and done held stable in DONE across idle cycles.
